divacc: RTL and testbench

DIVACC -- requirements
Module: divacc

---
 rtl/divacc.sv | 116 +++++++++++
 tb/tb_divacc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/divacc.sv
// Running-quotient accumulator: each accepted en replaces acc with acc / x
// using a WIDTH-step unsigned restoring divider, with sticky inexact/divzero flags.
module divacc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             inexact,
  output logic             divzero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             inx_q, inx_d;
  logic             dz_q, dz_d;

  // One restoring step. The trial value is WIDTH+1 bits wide so a divisor
  // with its top bit set still compares correctly; the restored remainder is
  // always below the divisor, so WIDTH bits suffice to store it.
  logic [WIDTH:0]   trial, rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             ge, last;

  always_comb begin
    trial    = {rem_q, dvd_q[WIDTH-1]};
    ge       = (trial >= {1'b0, dvs_q});
    rem_step = ge ? (trial - {1'b0, dvs_q}) : trial;
    quo_step = {dvd_q[WIDTH-2:0], ge};
    last     = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    inx_d   = inx_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          acc_d = x;
          inx_d = 1'b0;
          dz_d  = 1'b0;
        end else if (en) begin
          if (x == '0) begin
            dz_d    = 1'b1;
            state_d = FIN;
          end else begin
            dvs_d   = x;
            dvd_d   = acc_q;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d = rem_step[WIDTH-1:0];
        dvd_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          acc_d   = quo_step;
          inx_d   = inx_q | (rem_step != '0);
          cnt_d   = '0;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      inx_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      inx_q   <= inx_d;
      dz_q    <= dz_d;
    end
  end

  assign out     = acc_q;
  assign busy    = (state_q == DIV);
  assign done    = (state_q == FIN);
  assign inexact = inx_q;
  assign divzero = dz_q;
endmodule

// File: tb/tb_divacc.sv
// Randomised and directed bench for divacc at WIDTH=8 against a plain
// arithmetic model of the running quotient and its sticky flags.
module tb_divacc;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, load, en;
  logic [W-1:0] x;
  logic [W-1:0] out;
  logic         busy, done, inexact, divzero;

  int vectors = 0;
  int errs    = 0;

  int unsigned acc_m;
  bit          inx_m, dz_m;

  divacc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .en(en), .x(x),
    .out(out), .busy(busy), .done(done), .inexact(inexact), .divzero(divzero)
  );

  always #5 clk = ~clk;

  task automatic chk_all(input string name, input logic [W-1:0] o, input bit b,
                         input bit d, input bit ix, input bit dz);
    vectors++;
    if ({out, busy, done, inexact, divzero} !== {o, b, d, ix, dz}) begin
      errs++;
      $display("FAIL %s: got out=%0d busy=%b done=%b inx=%b dz=%b, want out=%0d busy=%b done=%b inx=%b dz=%b",
               name, out, busy, done, inexact, divzero, o, b, d, ix, dz);
    end
  endtask

  task automatic do_load(input int unsigned v);
    load = 1'b1; x = W'(v);
    @(negedge clk);
    load = 1'b0; x = W'($urandom);
    acc_m = v; inx_m = 0; dz_m = 0;
    chk_all("load", W'(acc_m), 0, 0, 0, 0);
  endtask

  // Starts a division from IDLE (caller is at a negedge) and checks every
  // cycle of the operation; disturb pokes load/en/x while it iterates.
  task automatic do_div(input int unsigned v, input bit disturb, input string name);
    en = 1'b1; x = W'(v);
    @(negedge clk);
    en = 1'b0; x = W'($urandom);
    if (v == 0) begin
      dz_m = 1;
    end else begin
      for (int i = 0; i < W; i++) begin
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errs++;
          $display("FAIL %s_busy[%0d]: got busy=%b done=%b, want busy=1 done=0", name, i, busy, done);
        end
        if (disturb) begin
          case (i)
            1: begin load = 1'b1; x = 9; end
            3: begin load = 1'b0; en = 1'b1; x = 2; end
            4: en = 1'b0;
            default: ;
          endcase
        end
        @(negedge clk);
      end
      inx_m = inx_m | ((acc_m % v) != 0);
      acc_m = acc_m / v;
    end
    chk_all({name, "_done"}, W'(acc_m), 0, 1, inx_m, dz_m);
    @(negedge clk);
    chk_all({name, "_idle"}, W'(acc_m), 0, 0, inx_m, dz_m);
  endtask

  task automatic test_reset;
    reset = 1'b0; load = 0; en = 0; x = '0;
    #1;
    chk_all("reset_async", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    acc_m = 0; inx_m = 0; dz_m = 0;
    @(negedge clk);
    chk_all("reset_release", 0, 0, 0, 0, 0);
  endtask

  task automatic test_directed;
    do_load(100);
    do_div(5, 0, "d100_5");
    do_div(3, 0, "d20_3");
    do_div(0, 0, "d6_0");
    do_load(255);
    // load wins over en at the same edge
    load = 1'b1; en = 1'b1; x = 200;
    @(negedge clk);
    load = 1'b0; en = 1'b0;
    acc_m = 200; inx_m = 0; dz_m = 0;
    chk_all("load_en", 200, 0, 0, 0, 0);
    @(negedge clk);
    chk_all("load_en_nodiv", 200, 0, 0, 0, 0);
    do_div(201, 0, "d200_201");
    do_load(255);
    do_div(128, 0, "d255_128");
    do_load(0);
    do_div(37, 0, "d0_37");
  endtask

  task automatic test_ignore_in_div;
    do_load(40);
    do_div(4, 1, "d40_4_dist");
    vectors++;
    if (out !== 8'd10) begin
      errs++;
      $display("FAIL ignore_in_div: got out=%0d, want 10", out);
    end
  endtask

  task automatic test_abort;
    bit seen_done = 0;
    do_load(100);
    en = 1'b1; x = 7;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    acc_m = 0; inx_m = 0; dz_m = 0;
    chk_all("abort_async", 0, 0, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    reset = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    vectors++;
    if (seen_done) begin
      errs++;
      $display("FAIL abort_no_done: got done/busy activity after abort, want none");
    end
    do_load(49);
    do_div(7, 0, "d49_7");
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      do_load($urandom_range(255, 0));
      for (int k = 0; k < int'($urandom_range(3, 1)); k++) begin
        int unsigned d;
        case ($urandom_range(3, 0))
          0: d = $urandom_range(255, 128);
          1: d = (($urandom_range(9, 0) == 0) ? 0 : $urandom_range(255, 1));
          default: d = $urandom_range(9, 1);
        endcase
        do_div(d, 0, "rand");
      end
    end
  endtask

  task automatic test_back_to_back;
    do_load(250);
    do_div(2, 0, "b2b_a");
    do_div(5, 0, "b2b_b");
    do_div(0, 0, "b2b_c");
    do_div(4, 0, "b2b_d");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ignore_in_div;
    test_abort;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
